pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and stall scheduler for the 16-bit 5-stage core. It sits beside the fetch/decode and decode/execute pipeline registers and generates every per-cycle control for them: the `flush_fd`/`nop_fd` pair of the fetch/decode register, the PC write enable, the decode/execute bubble, and a global freeze. It resolves three hazard sources: data-memory wait, taken branch, and load-use. It sequences multi-cycle stalls and flushes with a small state machine, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- `REG_W`, 4: register-address width.
- `BR_FLUSH_CYCLES`, 2: number of cycles, ≥1, during which fetch/decode and decode/execute are flushed after a taken branch.
- `LOAD_STALLS`, 2: number of bubble cycles, ≥1, inserted on a load-use hazard.
- `clk` input, 1: clock.
- `reset` input, 1: synchronous, active-high.
- `id_rs1`, `id_rs2` input, REG_W: source registers of the instruction in decode.
- `id_uses_rs1`, `id_uses_rs2` input, 1: the decode instruction actually reads that source.
- `ex_rd` input, REG_W: destination register of the instruction in execute.
- `ex_is_load` input, 1: the execute instruction is a load.
- `ex_branch_taken` input, 1: a branch or jump in execute resolved taken.
- `mem_req` input, 1: the memory stage has an access in progress.
- `mem_ready` input, 1: the memory access completes this cycle.
- `flush_fd` output, 2: fetch/decode flush. 2'b00 means pass; 2'b01 means load a zero instruction.
- `nop_fd` output, 2: fetch/decode hold. 2'b00 means advance; 2'b01 means hold contents.
- `pc_en` output, 1: PC register write enable.
- `flush_de` output, 1: load a bubble into decode/execute.
- `freeze` output, 1: hold decode/execute, execute/memory and memory/writeback.
- `stall_cycles` output, 16: count of cycles with `pc_en` = 0 since reset; saturates at 16'hFFFF.

## Operation
- States: RUN, LOAD_STALL, BR_FLUSH. There is a down-counter `cnt` of width `$clog2(max(BR_FLUSH_CYCLES, LOAD_STALLS)+1)`.
- Load-use hazard `luh` = `ex_is_load` & (`ex_rd` ≠ 0) & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)). Register 0 never hazards.
- Memory wait `mw` = `mem_req` & ~`mem_ready`. It overrides every state:
  - Outputs: `freeze`=1, `nop_fd`=01, `flush_fd`=00, `pc_en`=0, `flush_de`=0.
  - State and `cnt` hold.
- Priority within a cycle is `mw` > `ex_branch_taken` > `luh`.
- RUN (outputs are Mealy), one of three cases:
  - Taken branch: `flush_fd`=01, `flush_de`=1, `pc_en`=1. If `BR_FLUSH_CYCLES` > 1, go to BR_FLUSH with `cnt`=`BR_FLUSH_CYCLES`-1.
  - `luh`: `nop_fd`=01, `pc_en`=0, `flush_de`=1. If `LOAD_STALLS` > 1, go to LOAD_STALL with `cnt`=`LOAD_STALLS`-1.
  - Neither: all outputs idle, i.e. `flush_fd`=00, `nop_fd`=00, `pc_en`=1, `flush_de`=0, `freeze`=0.
- BR_FLUSH (outputs are Moore): `flush_fd`=01, `flush_de`=1, `pc_en`=1.
  - `cnt` decrements each cycle; go to RUN when `cnt`==1.
  - `ex_branch_taken` and `luh` are ignored, because execute holds a bubble.
- LOAD_STALL: `nop_fd`=01, `pc_en`=0, `flush_de`=1.
  - `cnt` decrements each cycle; go to RUN when `cnt`==1.
  - If `ex_branch_taken` occurs here, it aborts the stall and is handled exactly as the RUN branch case in the same cycle.
- `flush_fd` and `nop_fd` are never both nonzero.
- `stall_cycles` increments on every cycle where `pc_en`=0 and `reset`=0, and stops at 16'hFFFF.

## Timing
- Reset, which wins over every other input:
  - State goes to RUN, `cnt`=0, `stall_cycles`=0.
  - While `reset` is high: `flush_fd`=01, `nop_fd`=00, `pc_en`=0, `flush_de`=1, `freeze`=0.
  - Reset asserted mid-flush or mid-stall discards that sequence.
- Hazard response is zero-latency: the RUN outputs are combinational from the inputs in the same cycle.
- Branch flush lasts exactly `BR_FLUSH_CYCLES` non-frozen cycles.
- Load-use stall lasts exactly `LOAD_STALLS` non-frozen cycles, with `pc_en` low throughout.
- A `mw` cycle extends any sequence by exactly one cycle and does not consume `cnt`.
- `luh` and `ex_branch_taken` in the same RUN cycle result in the branch case only.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - The encodings `FD_PASS`=2'b00, `FD_FLUSH`=2'b01, `FD_ADV`=2'b00, `FD_HOLD`=2'b01.
  - The enum `hz_state_t` {RUN, LOAD_STALL, BR_FLUSH}.
- Sub-module `sat_counter`: a 16-bit saturating counter with increment enable, used for `stall_cycles`.
- Everything else lives in one `always_ff` (state, `cnt`) plus one `always_comb` (outputs).

## Test plan
- Reset held 3 cycles: `flush_fd`=01, `pc_en`=0, `flush_de`=1 each cycle. After release with no hazards: `flush_fd`=00, `nop_fd`=00, `pc_en`=1, `stall_cycles`=0.
- Load-use: `ex_is_load`=1, `ex_rd`=3, `id_rs2`=3, `id_uses_rs2`=1 → `nop_fd`=01, `pc_en`=0 for exactly 2 cycles, then idle; `stall_cycles`=2. Repeat with `ex_rd`=0 → no stall.
- Taken branch in RUN → `flush_fd`=01, `flush_de`=1 for 2 cycles. A second `ex_branch_taken` pulse in cycle 2 is ignored; RUN on cycle 3.
- Branch and `luh` asserted together → branch flush only, `pc_en`=1, `stall_cycles` unchanged.
- `mem_req`=1, `mem_ready`=0 for 4 cycles during cycle 1 of BR_FLUSH → `freeze`=1 and `nop_fd`=01 for 4 cycles, then 1 remaining flush cycle, then RUN.
- Reset pulsed mid LOAD_STALL → RUN on the following cycle, `stall_cycles`=0. Force 70000 stall cycles → `stall_cycles` stays at 16'hFFFF.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and types for the pipeline control blocks.
package cpu_ctrl_pkg;

    localparam logic [1:0] FD_PASS  = 2'b00;
    localparam logic [1:0] FD_FLUSH = 2'b01;
    localparam logic [1:0] FD_ADV   = 2'b00;
    localparam logic [1:0] FD_HOLD  = 2'b01;

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        BR_FLUSH
    } hz_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and synchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !(&count_q)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall scheduler driving the fetch/decode and decode/execute
// pipeline registers: memory wait, taken branch and load-use.
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W           = 4,
    parameter int BR_FLUSH_CYCLES = 2,
    parameter int LOAD_STALLS     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic [1:0]       flush_fd,
    output logic [1:0]       nop_fd,
    output logic             pc_en,
    output logic             flush_de,
    output logic             freeze,
    output logic [15:0]      stall_cycles
);

    localparam int CNT_MAX = max2(BR_FLUSH_CYCLES, LOAD_STALLS);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] BR_INIT = CNT_W'(BR_FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LS_INIT = CNT_W'(LOAD_STALLS - 1);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic luh;
    logic mw;
    logic go_br;

    assign luh = ex_is_load && (ex_rd != '0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign mw = mem_req && !mem_ready;

    // Execute holds a bubble during a branch flush, so a branch there is stale.
    assign go_br = ex_branch_taken && (state_q != BR_FLUSH);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flush_fd = FD_PASS;
        nop_fd   = FD_ADV;
        pc_en    = 1'b1;
        flush_de = 1'b0;
        freeze   = 1'b0;

        if (reset) begin
            state_d  = RUN;
            cnt_d    = '0;
            flush_fd = FD_FLUSH;
            pc_en    = 1'b0;
            flush_de = 1'b1;
        end else if (mw) begin
            freeze = 1'b1;
            nop_fd = FD_HOLD;
            pc_en  = 1'b0;
        end else if (go_br) begin
            flush_fd = FD_FLUSH;
            flush_de = 1'b1;
            if (BR_FLUSH_CYCLES > 1) begin
                state_d = BR_FLUSH;
                cnt_d   = BR_INIT;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (luh) begin
                        nop_fd   = FD_HOLD;
                        pc_en    = 1'b0;
                        flush_de = 1'b1;
                        if (LOAD_STALLS > 1) begin
                            state_d = LOAD_STALL;
                            cnt_d   = LS_INIT;
                        end
                    end
                end
                LOAD_STALL: begin
                    nop_fd   = FD_HOLD;
                    pc_en    = 1'b0;
                    flush_de = 1'b1;
                    cnt_d    = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = RUN;
                    end
                end
                BR_FLUSH: begin
                    flush_fd = FD_FLUSH;
                    flush_de = 1'b1;
                    cnt_d    = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(
        .W(16)
    ) u_stall_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (!pc_en),
        .count_o(stall_cycles)
    );

endmodule
